uart_matrix_loader: RTL
=======================

// Module: uart_matrix_loader
// PURPOSE
//  Frame controller between the UART byte receiver and the matrix-multiply core.
//  Waits for a sync byte, then writes N*N bytes of matrix A and N*N bytes of matrix B
//  into the operand buffers, pulses the multiplier start and holds off new frames until done.
//  Aborts partial frames on an inter-byte timeout so the link resynchronises.
// PARAMETERS
//  N          4       matrix dimension; frame payload = 2*N*N bytes
//  DATA_W     8       byte/element width
//  SYNC_BYTE  8'hA5   frame-start marker, recognised only in IDLE
//  TIMEOUT    64      max clk cycles between bytes inside LOAD_A/LOAD_B
//  ADDR_W     derived clog2(N*N) (localparam, not overridable)
// PORTS
//  clk        in   1       single clock (same clock as the UART receiver)
//  rst        in   1       synchronous, active-high reset
//  rx_data    in   DATA_W  received byte
//  rx_valid   in   1       receiver byte-valid, high >=2 cycles per byte
//  mem_we_a   out  1       write strobe, matrix A buffer
//  mem_we_b   out  1       write strobe, matrix B buffer
//  mem_addr   out  ADDR_W  element address, row-major (row*N+col)
//  mem_wdata  out  DATA_W  element data
//  mm_start   out  1       one-cycle start pulse to multiplier
//  mm_done    in   1       multiplier completion (pulse or level)
//  busy       out  1       high in every state except IDLE
//  frame_err  out  1       one-cycle pulse on timeout abort
//  overrun    out  1       sticky: byte arrived during START/WAIT_DONE and was dropped
// BEHAVIOUR
//  - Byte acceptance: byte taken on cycle rx_valid falls (rx_valid_q=1 & rx_valid=0);
//    rx_data sampled that cycle. Exactly one acceptance per rx_valid high period.
//  - Reset: state=IDLE, all outputs 0, counters 0, overrun cleared, rx_valid_q=0.
//    Reset mid-frame discards the frame; no write or mm_start after rst.
//  - States: IDLE -> LOAD_A -> LOAD_B -> START -> WAIT_DONE -> IDLE.
//  - IDLE: accepted byte==SYNC_BYTE -> LOAD_A, idx=0, overrun cleared; other bytes dropped silently.
//  - LOAD_A/LOAD_B: each accepted byte -> next cycle mem_we_x=1, mem_addr=idx, mem_wdata=byte
//    (latency 1, strobe exactly 1 cycle). idx increments; at idx=N*N-1 wraps to 0 and
//    LOAD_A->LOAD_B / LOAD_B->START. SYNC_BYTE value is plain data here.
//  - START: mm_start=1 for one cycle (the cycle after last B write strobe), then WAIT_DONE.
//  - WAIT_DONE: mm_done=1 -> IDLE next cycle. mm_done ignored in all other states.
//  - START/WAIT_DONE: accepted bytes dropped, overrun<=1 (sticky until reset or next sync).
//  - Timeout: tmo counter clears on entry to LOAD_A and on every accepted byte; counts each
//    cycle in LOAD_A/LOAD_B; when it reaches TIMEOUT-1 with no byte -> IDLE, frame_err=1
//    one cycle. Already-written elements are not rolled back.
//  - Simultaneous: byte accepted on the timeout cycle -> byte wins, counter clears, no error.
//  - mem_addr/mem_wdata hold last value when no strobe; only strobes are qualified.
//  - busy is combinational from state; all other outputs registered.
// STRUCTURE
//  - Package matmul_pkg: N, DATA_W, SYNC_BYTE, state encoding constants
//    (IDLE, LOAD_A, LOAD_B, START, WAIT_DONE), shared with multiplier and buffers.
//  - Sub-module rx_byte_strobe: registers rx_valid, emits one-cycle byte_stb + byte on
//    falling edge. Remainder (FSM, idx, tmo counter) lives in this module.
// TESTING
//  1. A5, then 1..16, then 17..32 (N=4) -> 16 mem_we_a at addr 0..15 data 1..16, 16 mem_we_b
//     data 17..32, mm_start 1 cycle after last B strobe; mm_done -> busy=0.
//  2. Bytes 00,FF,3C before A5 -> no writes, busy=0; A5 then enters LOAD_A.
//  3. A5 + 5 bytes, then silence 64 cycles -> frame_err pulse, IDLE, no mm_start;
//     subsequent full frame loads from addr 0.
//  4. Byte arriving in WAIT_DONE -> no write, overrun=1; next A5 clears overrun.
//  5. rst asserted after 10 A bytes -> outputs 0 next cycle, no further strobes;
//     rx_valid held high 4 cycles -> exactly one write.
//  6. Byte accepted exactly on tmo=TIMEOUT-1 -> written, no frame_err; A5 inside payload
//     -> written as data.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_pkg
//  Description : Shared constants for the UART matrix loader, the operand
//                buffers and the matrix-multiply core: matrix dimension,
//                element width, frame sync marker, inter-byte timeout and
//                the loader state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package matmul_pkg;

    localparam int          c_N         = 4;
    localparam int          c_DATA_W    = 8;
    localparam logic [7:0]  c_SYNC_BYTE = 8'hA5;
    localparam int          c_TIMEOUT   = 64;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_LOAD_A    = 3'd1;
    localparam state_t c_ST_LOAD_B    = 3'd2;
    localparam state_t c_ST_START     = 3'd3;
    localparam state_t c_ST_WAIT_DONE = 3'd4;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/rx_byte_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : rx_byte_strobe
//  Description : Turns the UART receiver's multi-cycle rx_valid level into a
//                single-cycle byte strobe on its falling edge. The byte is
//                taken from the receiver in that same cycle.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                i_rx_data       received byte
//                i_rx_valid      receiver byte-valid (level, >=2 cycles)
//                o_byte_stb      one-cycle strobe, rx_valid falling edge
//                o_byte          byte accompanying o_byte_stb
//  Revision    : 1.0  initial release
// ============================================================================
module rx_byte_strobe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_byte_stb,
    output logic [DATA_W-1:0] o_byte
);

    logic r_rx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid_q <= 1'b0;
        end else begin
            r_rx_valid_q <= i_rx_valid;
        end
    end

    // Falling edge gives exactly one strobe per high period, however long
    // the receiver holds rx_valid.
    assign o_byte_stb = r_rx_valid_q & ~i_rx_valid;
    assign o_byte     = i_rx_data;

endmodule : rx_byte_strobe
`default_nettype wire

// File: rtl/uart_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_matrix_loader
//  Description : Frame controller between the UART byte receiver and the
//                matrix-multiply core. Waits for a sync byte, writes N*N
//                bytes of A then N*N bytes of B into the operand buffers,
//                pulses mm_start and holds off new frames until mm_done.
//                An inter-byte timeout aborts partial frames.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                rx_data/rx_valid  byte from UART receiver
//                mem_we_a/_b     write strobes for A / B operand buffers
//                mem_addr        row-major element address
//                mem_wdata       element data
//                mm_start        one-cycle multiplier start
//                mm_done         multiplier completion (pulse or level)
//                busy            high whenever not IDLE (combinational)
//                frame_err       one-cycle pulse on timeout abort
//                overrun         sticky, byte dropped during START/WAIT_DONE
//  Revision    : 1.0  initial release
// ============================================================================
module uart_matrix_loader
    import matmul_pkg::*;
#(
    parameter int                N         = c_N,
    parameter int                DATA_W    = c_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(c_SYNC_BYTE),
    parameter int                TIMEOUT   = c_TIMEOUT,
    localparam int               ADDR_W    = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              mem_we_a,
    output logic              mem_we_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mm_start,
    input  logic              mm_done,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int                TMO_W      = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] c_IDX_LAST = ADDR_W'(N*N-1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'(TIMEOUT-1);

    // ------------------------------------------------------------------
    // Byte strobe
    // ------------------------------------------------------------------
    logic              w_stb;
    logic [DATA_W-1:0] w_byte;

    rx_byte_strobe #(
        .DATA_W (DATA_W)
    ) u_rx_byte_strobe (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_byte_stb (w_stb),
        .o_byte     (w_byte)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_we_a;
    logic              r_mem_we_b;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mm_start;
    logic              r_frame_err;
    logic              r_overrun;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    logic w_loading;
    logic w_sync_hit;
    logic w_idx_last;
    logic w_tmo_expire;
    logic w_drop;

    assign w_loading    = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B);
    assign w_sync_hit   = (r_state == c_ST_IDLE) && w_stb && (w_byte == SYNC_BYTE);
    assign w_idx_last   = (r_idx == c_IDX_LAST);
    // A byte landing on the last timeout cycle wins over the abort.
    assign w_tmo_expire = w_loading && !w_stb && (r_tmo == c_TMO_LAST);
    assign w_drop       = w_stb && ((r_state == c_ST_START) || (r_state == c_ST_WAIT_DONE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sync_hit) w_state_nxt = c_ST_LOAD_A;
            end
            c_ST_LOAD_A: begin
                if (w_stb && w_idx_last) w_state_nxt = c_ST_LOAD_B;
                else if (w_tmo_expire)   w_state_nxt = c_ST_IDLE;
            end
            c_ST_LOAD_B: begin
                if (w_stb && w_idx_last) w_state_nxt = c_ST_START;
                else if (w_tmo_expire)   w_state_nxt = c_ST_IDLE;
            end
            c_ST_START: begin
                w_state_nxt = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (mm_done) w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (next values of the registered outputs, plus busy)
    // ------------------------------------------------------------------
    logic w_we_a_nxt;
    logic w_we_b_nxt;
    logic w_mm_start_nxt;

    always_comb begin
        w_we_a_nxt     = (r_state == c_ST_LOAD_A) && w_stb;
        w_we_b_nxt     = (r_state == c_ST_LOAD_B) && w_stb;
        w_mm_start_nxt = (r_state == c_ST_START);
        busy           = (r_state != c_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_tmo       <= '0;
            r_mem_we_a  <= 1'b0;
            r_mem_we_b  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mm_start  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mem_we_a  <= w_we_a_nxt;
            r_mem_we_b  <= w_we_b_nxt;
            r_mm_start  <= w_mm_start_nxt;
            r_frame_err <= w_tmo_expire;

            // Address/data hold between strobes; only the strobes qualify.
            if (w_we_a_nxt || w_we_b_nxt) begin
                r_mem_addr  <= r_idx;
                r_mem_wdata <= w_byte;
            end

            // Element index: parked at 0 outside loading, wraps between A and B.
            if (!w_loading) begin
                r_idx <= '0;
            end else if (w_stb) begin
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end

            // Inter-byte timer: zero outside loading and on every byte.
            if (!w_loading || w_stb) begin
                r_tmo <= '0;
            end else if (r_tmo != c_TMO_LAST) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_sync_hit) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign mem_we_a  = r_mem_we_a;
    assign mem_we_b  = r_mem_we_b;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mm_start  = r_mm_start;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_matrix_loader
`default_nettype wire
